rs_issue_sched: RTL and testbench

Eight-entry reservation-station issue scheduler for one execution unit. It allocates entries to dispatched instructions and tracks operand readiness through tag wakeup broadcasts. Each cycle it selects the oldest ready entry by an age key of {not-ready, sortbit, RRF tag} and presents it to the execution unit on a registered valid/ack handshake. It sits between the dispatch stage and the ALU/issue datapath and wraps the eight-input oldest-entry comparator tree.

---
 rtl/rs_issue_sched.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rs_issue_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// rs_issue_sched: 8-entry reservation station with tag wakeup, oldest-ready select and registered issue.
// Build option: define ISSUE_SCHED_OLDEST_EN for age-key select; otherwise the lowest-index READY entry issues.
module rs_issue_sched #(
  parameter int RRF_SEL = 6,
  parameter int ENTLEN  = 3
) (
  input  logic               clk,
  input  logic               reset_x,
  input  logic               flush,
  input  logic               rrf_wrap,
  input  logic               dp_req0,
  input  logic               dp_req1,
  input  logic [RRF_SEL-1:0] dp_tag0,
  input  logic [RRF_SEL-1:0] dp_tag1,
  input  logic [RRF_SEL-1:0] dp_s1tag0,
  input  logic [RRF_SEL-1:0] dp_s1tag1,
  input  logic [RRF_SEL-1:0] dp_s2tag0,
  input  logic [RRF_SEL-1:0] dp_s2tag1,
  input  logic               dp_s1rdy0,
  input  logic               dp_s1rdy1,
  input  logic               dp_s2rdy0,
  input  logic               dp_s2rdy1,
  output logic               alloc_ok,
  input  logic               wk_en0,
  input  logic               wk_en1,
  input  logic [RRF_SEL-1:0] wk_tag0,
  input  logic [RRF_SEL-1:0] wk_tag1,
  output logic               issue_valid,
  output logic [ENTLEN-1:0]  issue_ent,
  output logic [RRF_SEL-1:0] issue_tag,
  input  logic               issue_ack,
  output logic [3:0]         busy_cnt
);
  localparam int NENT   = 8;
  localparam int VALLEN = RRF_SEL + 2;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_ISSUED} ent_state_e;

  ent_state_e         state_q [NENT];
  ent_state_e         state_d [NENT];
  logic [RRF_SEL-1:0] tag_q   [NENT];
  logic [RRF_SEL-1:0] tag_d   [NENT];
  logic [RRF_SEL-1:0] s1tag_q [NENT];
  logic [RRF_SEL-1:0] s1tag_d [NENT];
  logic [RRF_SEL-1:0] s2tag_q [NENT];
  logic [RRF_SEL-1:0] s2tag_d [NENT];
  logic               s1rdy_q [NENT];
  logic               s1rdy_d [NENT];
  logic               s2rdy_q [NENT];
  logic               s2rdy_d [NENT];
`ifdef ISSUE_SCHED_OLDEST_EN
  logic               sortbit_q [NENT];
  logic               sortbit_d [NENT];
`else
  logic               unused_rrf_wrap;
  assign unused_rrf_wrap = rrf_wrap;
`endif

  logic               issue_valid_q, issue_valid_d;
  logic [ENTLEN-1:0]  issue_ent_q, issue_ent_d;
  logic [RRF_SEL-1:0] issue_tag_q, issue_tag_d;

  function automatic logic wake_hit(input logic [RRF_SEL-1:0] t,
                                    input logic en0, input logic [RRF_SEL-1:0] t0,
                                    input logic en1, input logic [RRF_SEL-1:0] t1);
    return (en0 && (t0 == t)) || (en1 && (t1 == t));
  endfunction

  // Occupancy and free-entry search use registered state only, so a freed entry waits a cycle.
  logic [3:0]        busy;
  logic              found0, found1;
  logic [ENTLEN-1:0] free0_idx, free1_idx;

  always_comb begin
    busy      = '0;
    found0    = 1'b0;
    found1    = 1'b0;
    free0_idx = '0;
    free1_idx = '0;
    for (int i = 0; i < NENT; i++) begin
      if (state_q[i] != ST_FREE) begin
        busy = busy + 4'd1;
      end else if (!found0) begin
        found0    = 1'b1;
        free0_idx = ENTLEN'(i);
      end else if (!found1) begin
        found1    = 1'b1;
        free1_idx = ENTLEN'(i);
      end
    end
  end

  assign busy_cnt = busy;
  assign alloc_ok = (busy <= 4'(NENT - 2));

  // Comparator tree: leaves hold per-entry keys, ties resolve toward the lower index.
  logic [VALLEN-1:0] key_l0 [8];
  logic [ENTLEN-1:0] idx_l0 [8];
  logic [VALLEN-1:0] key_l1 [4];
  logic [ENTLEN-1:0] idx_l1 [4];
  logic [VALLEN-1:0] key_l2 [2];
  logic [ENTLEN-1:0] idx_l2 [2];
  logic [VALLEN-1:0] win_key;
  logic [ENTLEN-1:0] win_idx;
  logic              win_valid;

  genvar gi;
  for (gi = 0; gi < NENT; gi++) begin : g_leaf
    logic cand;
    assign cand = (state_q[gi] == ST_READY);
`ifdef ISSUE_SCHED_OLDEST_EN
    assign key_l0[gi] = cand ? {1'b0, sortbit_q[gi], tag_q[gi]} : '1;
`else
    assign key_l0[gi] = cand ? '0 : '1;
`endif
    assign idx_l0[gi] = ENTLEN'(gi);
  end

  for (gi = 0; gi < 4; gi++) begin : g_l1
    logic take_left;
    assign take_left  = key_l0[2*gi] <= key_l0[2*gi+1];
    assign key_l1[gi] = take_left ? key_l0[2*gi] : key_l0[2*gi+1];
    assign idx_l1[gi] = take_left ? idx_l0[2*gi] : idx_l0[2*gi+1];
  end

  for (gi = 0; gi < 2; gi++) begin : g_l2
    logic take_left;
    assign take_left  = key_l1[2*gi] <= key_l1[2*gi+1];
    assign key_l2[gi] = take_left ? key_l1[2*gi] : key_l1[2*gi+1];
    assign idx_l2[gi] = take_left ? idx_l1[2*gi] : idx_l1[2*gi+1];
  end

  assign win_key   = (key_l2[0] <= key_l2[1]) ? key_l2[0] : key_l2[1];
  assign win_idx   = (key_l2[0] <= key_l2[1]) ? idx_l2[0] : idx_l2[1];
  assign win_valid = ~win_key[VALLEN-1];

  logic              ack_fire, load;
  logic [ENTLEN-1:0] d0_idx, d1_idx;
  logic              d0_s1rdy, d0_s2rdy, d1_s1rdy, d1_s2rdy;

  assign ack_fire = issue_valid_q && issue_ack;
  assign load     = win_valid && (!issue_valid_q || issue_ack);
  assign d0_idx   = free0_idx;
  assign d1_idx   = dp_req0 ? free1_idx : free0_idx;
  assign d0_s1rdy = dp_s1rdy0 | wake_hit(dp_s1tag0, wk_en0, wk_tag0, wk_en1, wk_tag1);
  assign d0_s2rdy = dp_s2rdy0 | wake_hit(dp_s2tag0, wk_en0, wk_tag0, wk_en1, wk_tag1);
  assign d1_s1rdy = dp_s1rdy1 | wake_hit(dp_s1tag1, wk_en0, wk_tag0, wk_en1, wk_tag1);
  assign d1_s2rdy = dp_s2rdy1 | wake_hit(dp_s2tag1, wk_en0, wk_tag0, wk_en1, wk_tag1);

  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      state_d[i] = state_q[i];
      tag_d[i]   = tag_q[i];
      s1tag_d[i] = s1tag_q[i];
      s2tag_d[i] = s2tag_q[i];
      s1rdy_d[i] = s1rdy_q[i];
      s2rdy_d[i] = s2rdy_q[i];
`ifdef ISSUE_SCHED_OLDEST_EN
      sortbit_d[i] = sortbit_q[i];
`endif
    end
    issue_valid_d = issue_valid_q;
    issue_ent_d   = issue_ent_q;
    issue_tag_d   = issue_tag_q;

    for (int i = 0; i < NENT; i++) begin
      if (state_q[i] == ST_WAIT) begin
        s1rdy_d[i] = s1rdy_q[i] | wake_hit(s1tag_q[i], wk_en0, wk_tag0, wk_en1, wk_tag1);
        s2rdy_d[i] = s2rdy_q[i] | wake_hit(s2tag_q[i], wk_en0, wk_tag0, wk_en1, wk_tag1);
        if (s1rdy_d[i] && s2rdy_d[i]) state_d[i] = ST_READY;
      end
`ifdef ISSUE_SCHED_OLDEST_EN
      if (rrf_wrap && (state_q[i] != ST_FREE)) sortbit_d[i] = 1'b0;
`endif
    end

    if (ack_fire) state_d[issue_ent_q] = ST_FREE;

    if (load) begin
      state_d[win_idx] = ST_ISSUED;
      issue_valid_d    = 1'b1;
      issue_ent_d      = win_idx;
      issue_tag_d      = tag_q[win_idx];
    end else if (ack_fire) begin
      issue_valid_d = 1'b0;
    end

    // Dispatch targets entries that were FREE before this edge, never the ones above.
    if (alloc_ok && dp_req0) begin
      state_d[d0_idx] = (d0_s1rdy && d0_s2rdy) ? ST_READY : ST_WAIT;
      tag_d[d0_idx]   = dp_tag0;
      s1tag_d[d0_idx] = dp_s1tag0;
      s2tag_d[d0_idx] = dp_s2tag0;
      s1rdy_d[d0_idx] = d0_s1rdy;
      s2rdy_d[d0_idx] = d0_s2rdy;
`ifdef ISSUE_SCHED_OLDEST_EN
      sortbit_d[d0_idx] = 1'b1;
`endif
    end
    if (alloc_ok && dp_req1) begin
      state_d[d1_idx] = (d1_s1rdy && d1_s2rdy) ? ST_READY : ST_WAIT;
      tag_d[d1_idx]   = dp_tag1;
      s1tag_d[d1_idx] = dp_s1tag1;
      s2tag_d[d1_idx] = dp_s2tag1;
      s1rdy_d[d1_idx] = d1_s1rdy;
      s2rdy_d[d1_idx] = d1_s2rdy;
`ifdef ISSUE_SCHED_OLDEST_EN
      sortbit_d[d1_idx] = 1'b1;
`endif
    end

    if (flush) begin
      for (int i = 0; i < NENT; i++) begin
        state_d[i] = ST_FREE;
`ifdef ISSUE_SCHED_OLDEST_EN
        sortbit_d[i] = 1'b0;
`endif
      end
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      for (int i = 0; i < NENT; i++) begin
        state_q[i] <= ST_FREE;
        tag_q[i]   <= '0;
        s1tag_q[i] <= '0;
        s2tag_q[i] <= '0;
        s1rdy_q[i] <= 1'b0;
        s2rdy_q[i] <= 1'b0;
`ifdef ISSUE_SCHED_OLDEST_EN
        sortbit_q[i] <= 1'b0;
`endif
      end
      issue_valid_q <= 1'b0;
      issue_ent_q   <= '0;
      issue_tag_q   <= '0;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        state_q[i] <= state_d[i];
        tag_q[i]   <= tag_d[i];
        s1tag_q[i] <= s1tag_d[i];
        s2tag_q[i] <= s2tag_d[i];
        s1rdy_q[i] <= s1rdy_d[i];
        s2rdy_q[i] <= s2rdy_d[i];
`ifdef ISSUE_SCHED_OLDEST_EN
        sortbit_q[i] <= sortbit_d[i];
`endif
      end
      issue_valid_q <= issue_valid_d;
      issue_ent_q   <= issue_ent_d;
      issue_tag_q   <= issue_tag_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_ent   = issue_ent_q;
  assign issue_tag   = issue_tag_q;

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed scenarios plus random traffic against an entry-level reference model.
module tb_rs_issue_sched;
  localparam int RRF_SEL = 6;
  localparam int ENTLEN  = 3;
  localparam int NENT    = 8;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  logic flush, rrf_wrap, dp_req0, dp_req1;
  logic [RRF_SEL-1:0] dp_tag0, dp_tag1, dp_s1tag0, dp_s1tag1, dp_s2tag0, dp_s2tag1;
  logic dp_s1rdy0, dp_s1rdy1, dp_s2rdy0, dp_s2rdy1;
  logic alloc_ok;
  logic wk_en0, wk_en1;
  logic [RRF_SEL-1:0] wk_tag0, wk_tag1;
  logic issue_valid;
  logic [ENTLEN-1:0] issue_ent;
  logic [RRF_SEL-1:0] issue_tag;
  logic issue_ack;
  logic [3:0] busy_cnt;

  always #5 clk = ~clk;

  rs_issue_sched #(.RRF_SEL(RRF_SEL), .ENTLEN(ENTLEN)) dut (
    .clk(clk), .reset_x(reset_x), .flush(flush), .rrf_wrap(rrf_wrap),
    .dp_req0(dp_req0), .dp_req1(dp_req1), .dp_tag0(dp_tag0), .dp_tag1(dp_tag1),
    .dp_s1tag0(dp_s1tag0), .dp_s1tag1(dp_s1tag1), .dp_s2tag0(dp_s2tag0), .dp_s2tag1(dp_s2tag1),
    .dp_s1rdy0(dp_s1rdy0), .dp_s1rdy1(dp_s1rdy1), .dp_s2rdy0(dp_s2rdy0), .dp_s2rdy1(dp_s2rdy1),
    .alloc_ok(alloc_ok), .wk_en0(wk_en0), .wk_en1(wk_en1), .wk_tag0(wk_tag0), .wk_tag1(wk_tag1),
    .issue_valid(issue_valid), .issue_ent(issue_ent), .issue_tag(issue_tag),
    .issue_ack(issue_ack), .busy_cnt(busy_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: occupied/issued flags, operand readiness and the wrap epoch each entry was born in.
  bit         m_occ [NENT];
  bit         m_iss [NENT];
  bit         m_r1  [NENT];
  bit         m_r2  [NENT];
  logic [5:0] m_tag [NENT];
  logic [5:0] m_s1t [NENT];
  logic [5:0] m_s2t [NENT];
  int         m_epoch [NENT];
  int         m_wraps;
  bit         m_valid;
  int         m_ent;
  logic [5:0] m_itag;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic bit woke(input logic [5:0] t);
    return (wk_en0 && wk_tag0 == t) || (wk_en1 && wk_tag1 == t);
  endfunction

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < NENT; i++) if (m_occ[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_occ[i] = 0; m_iss[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_epoch[i] = 0;
      m_tag[i] = '0; m_s1t[i] = '0; m_s2t[i] = '0;
    end
    m_wraps = 0; m_valid = 0; m_ent = 0; m_itag = '0;
  endtask

  task automatic alloc(input int e, input logic [5:0] t, input logic [5:0] s1, input logic [5:0] s2,
                       input logic r1, input logic r2);
    m_occ[e] = 1; m_iss[e] = 0; m_tag[e] = t; m_s1t[e] = s1; m_s2t[e] = s2;
    m_r1[e] = r1 | woke(s1); m_r2[e] = r2 | woke(s2); m_epoch[e] = m_wraps;
  endtask

  task automatic model_edge();
    bit pre_occ [NENT];
    int free_q[$];
    int win, best, key;
    bit aok;
    if (flush) begin
      for (int i = 0; i < NENT; i++) begin m_occ[i] = 0; m_iss[i] = 0; end
      m_valid = 0;
      if (rrf_wrap) m_wraps++;
      return;
    end
    aok = busy_count() <= NENT - 2;
    pre_occ = m_occ;
    win = -1; best = 1 << 30;
    for (int i = 0; i < NENT; i++) begin
      if (m_occ[i] && !m_iss[i] && m_r1[i] && m_r2[i]) begin
`ifdef ISSUE_SCHED_OLDEST_EN
        key = ((m_epoch[i] == m_wraps) ? 64 : 0) + int'(m_tag[i]);
`else
        key = i;
`endif
        if (key < best) begin best = key; win = i; end
      end
    end
    if (m_valid && issue_ack) begin m_occ[m_ent] = 0; m_iss[m_ent] = 0; end
    for (int i = 0; i < NENT; i++) begin
      if (pre_occ[i]) begin
        m_r1[i] = m_r1[i] | woke(m_s1t[i]);
        m_r2[i] = m_r2[i] | woke(m_s2t[i]);
      end
    end
    if (rrf_wrap) m_wraps++;
    if (aok) begin
      for (int i = 0; i < NENT; i++) if (!pre_occ[i]) free_q.push_back(i);
      if (dp_req0) alloc(free_q.pop_front(), dp_tag0, dp_s1tag0, dp_s2tag0, dp_s1rdy0, dp_s2rdy0);
      if (dp_req1) alloc(free_q.pop_front(), dp_tag1, dp_s1tag1, dp_s2tag1, dp_s1rdy1, dp_s2rdy1);
    end
    if (win >= 0 && (!m_valid || issue_ack)) begin
      m_iss[win] = 1; m_valid = 1; m_ent = win; m_itag = m_tag[win];
    end else if (issue_ack) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs();
    int b;
    b = busy_count();
    chk("issue_valid", issue_valid, m_valid);
    if (m_valid) begin
      chk("issue_ent", issue_ent, m_ent);
      chk("issue_tag", issue_tag, m_itag);
    end
    chk("busy_cnt", busy_cnt, b);
    chk("alloc_ok", alloc_ok, (b <= NENT - 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    flush = 0; rrf_wrap = 0; dp_req0 = 0; dp_req1 = 0; wk_en0 = 0; wk_en1 = 0; issue_ack = 0;
    dp_tag0 = '0; dp_tag1 = '0; dp_s1tag0 = '0; dp_s1tag1 = '0; dp_s2tag0 = '0; dp_s2tag1 = '0;
    dp_s1rdy0 = 0; dp_s1rdy1 = 0; dp_s2rdy0 = 0; dp_s2rdy1 = 0; wk_tag0 = '0; wk_tag1 = '0;
  endtask

  task automatic disp0(input logic [5:0] t, input logic [5:0] s1, input logic [5:0] s2,
                       input logic r1, input logic r2);
    dp_req0 = 1; dp_tag0 = t; dp_s1tag0 = s1; dp_s2tag0 = s2; dp_s1rdy0 = r1; dp_s2rdy0 = r2;
  endtask

  task automatic disp1(input logic [5:0] t, input logic [5:0] s1, input logic [5:0] s2,
                       input logic r1, input logic r2);
    dp_req1 = 1; dp_tag1 = t; dp_s1tag1 = s1; dp_s2tag1 = s2; dp_s1rdy1 = r1; dp_s2rdy1 = r2;
  endtask

  function automatic logic [5:0] pick_tag(input logic [5:0] avoid, input bit use_avoid);
    logic [5:0] t;
    bit clash;
    t = '0;
    for (int tries = 0; tries < 1000; tries++) begin
      t = 6'($urandom_range(0, 63));
      clash = use_avoid && (t == avoid);
      for (int i = 0; i < NENT; i++) if (m_occ[i] && m_tag[i] == t) clash = 1;
      if (!clash) return t;
    end
    return t;
  endfunction

  initial begin
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", issue_valid, 0);
    chk("rst_ent", issue_ent, 0);
    chk("rst_tag", issue_tag, 0);
    chk("rst_busy", busy_cnt, 0);
    chk("rst_alloc_ok", alloc_ok, 1);
    reset_x = 1;

    // Single ready dispatch: issue two cycles later, ack frees it.
    idle(); disp0(6'd5, 6'd0, 6'd0, 1, 1); step();
    idle(); step();
    chk("t1_valid", issue_valid, 1);
    chk("t1_ent", issue_ent, 0);
    chk("t1_tag", issue_tag, 5);
    idle(); issue_ack = 1; step();
    chk("t1_busy", busy_cnt, 0);

    // Two ready entries with ack held: back-to-back issue.
    idle(); issue_ack = 1; disp0(6'd9, 6'd0, 6'd0, 1, 1); disp1(6'd3, 6'd0, 6'd0, 1, 1); step();
    idle(); issue_ack = 1; step();
`ifdef ISSUE_SCHED_OLDEST_EN
    chk("t2_first_tag", issue_tag, 3);
`else
    chk("t2_first_tag", issue_tag, 9);
`endif
    step();
`ifdef ISSUE_SCHED_OLDEST_EN
    chk("t2_second_tag", issue_tag, 9);
`else
    chk("t2_second_tag", issue_tag, 3);
`endif
    step();
    chk("t2_drained", issue_valid, 0);

    // Wrap: tag 60 born before the wrap is older than tag 2 born after it.
    idle(); flush = 1; step();
    idle(); disp0(6'd60, 6'd40, 6'd0, 0, 1); step();
    idle(); rrf_wrap = 1; step();
    idle(); disp0(6'd2, 6'd41, 6'd0, 0, 1); step();
    idle(); wk_en0 = 1; wk_tag0 = 6'd40; wk_en1 = 1; wk_tag1 = 6'd41; step();
    idle(); step();
    chk("t3_first_tag", issue_tag, 60);
    idle(); issue_ack = 1; step();
    chk("t3_second_tag", issue_tag, 2);
    step();
    chk("t3_drained", issue_valid, 0);

    // Dispatch bypass: the wakeup in the dispatch cycle is captured.
    idle(); disp0(6'd7, 6'd12, 6'd0, 0, 1); wk_en0 = 1; wk_tag0 = 6'd12; step();
    idle(); step();
    chk("t4_valid", issue_valid, 1);
    chk("t4_tag", issue_tag, 7);
    idle(); issue_ack = 1; step();
    chk("t4_busy", busy_cnt, 0);

    // Fill all entries with pending operands, then flush.
    for (int k = 0; k < 4; k++) begin
      idle();
      disp0(6'(30 + 2 * k), 6'd50, 6'd0, 0, 1);
      disp1(6'(31 + 2 * k), 6'd50, 6'd0, 0, 1);
      step();
    end
    chk("t5_full_alloc_ok", alloc_ok, 0);
    chk("t5_full_busy", busy_cnt, 8);
    idle(); flush = 1; step();
    chk("t5_flush_busy", busy_cnt, 0);
    chk("t5_flush_alloc_ok", alloc_ok, 1);
    chk("t5_flush_valid", issue_valid, 0);

    // Stall: held issue stays put while ack is low.
    idle(); disp0(6'd20, 6'd0, 6'd0, 1, 1); disp1(6'd21, 6'd0, 6'd0, 1, 1); step();
    idle(); step();
    chk("t6_tag", issue_tag, 20);
    for (int k = 0; k < 5; k++) begin
      idle(); step();
      chk("t6_hold_valid", issue_valid, 1);
      chk("t6_hold_ent", issue_ent, 0);
      chk("t6_hold_tag", issue_tag, 20);
    end
    idle(); issue_ack = 1; step();
    chk("t6_next_ent", issue_ent, 1);
    chk("t6_next_tag", issue_tag, 21);
    step();
    chk("t6_drained", issue_valid, 0);

    // Asynchronous reset mid-handshake.
    idle(); disp0(6'd33, 6'd0, 6'd0, 1, 1); step();
    idle(); step();
    chk("t7_valid_before", issue_valid, 1);
    #2;
    reset_x = 0;
    #1;
    chk("t7_async_valid", issue_valid, 0);
    chk("t7_async_ent", issue_ent, 0);
    chk("t7_async_tag", issue_tag, 0);
    chk("t7_async_busy", busy_cnt, 0);
    chk("t7_async_alloc_ok", alloc_ok, 1);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    reset_x = 1;

    // Random traffic checked every cycle against the model.
    for (int c = 0; c < 600; c++) begin
      logic [5:0] t0;
      logic [5:0] pend[$];
      bit can_wrap;
      idle();
      pend.delete();
      t0 = '0;
      if (busy_count() <= NENT - 2) begin
        if ($urandom_range(0, 2) != 0) begin
          t0 = pick_tag(6'd0, 1'b0);
          disp0(t0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        if ($urandom_range(0, 2) != 0) begin
          disp1(pick_tag(t0, dp_req0), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      for (int i = 0; i < NENT; i++) begin
        if (m_occ[i] && !m_iss[i]) begin
          if (!m_r1[i]) pend.push_back(m_s1t[i]);
          if (!m_r2[i]) pend.push_back(m_s2t[i]);
        end
      end
      if ($urandom_range(0, 1) != 0) begin
        wk_en0 = 1;
        wk_tag0 = (pend.size() > 0 && $urandom_range(0, 3) != 0) ?
                  pend[$urandom_range(0, pend.size() - 1)] : 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 1) != 0) begin
        wk_en1 = 1;
        wk_tag1 = (pend.size() > 0 && $urandom_range(0, 3) != 0) ?
                  pend[$urandom_range(0, pend.size() - 1)] : 6'($urandom_range(0, 63));
      end
      can_wrap = 1;
      for (int i = 0; i < NENT; i++) if (m_occ[i] && m_epoch[i] != m_wraps) can_wrap = 0;
      rrf_wrap  = can_wrap && ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      issue_ack = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
